// File: rtl/parser_ng.sv
// Table-driven header-chain parser: one header per PARSE cycle, ready_o k edges after launch for k headers.
// Start/ready handshake only; config writes are dropped (not stalled) while cfg_ready_o is low.
module parser_ng #(
  parameter int NUM_HDRS   = 4,
  parameter int TABLE_SIZE = 4,
  parameter int ADDR_W     = 32,
  parameter int HID_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          pkt_addr_i,
  output logic                       mem_ce_o,
  output logic                       mem_we_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [3:0]                 mem_width_o,
  output logic [31:0]                mem_data_o,
  input  logic [31:0]                mem_data_i,
  input  logic                       cfg_we_i,
  input  logic                       cfg_sel_i,
  input  logic [HID_W-1:0]           cfg_hdr_i,
  input  logic [HID_W-1:0]           cfg_idx_i,
  input  logic [31:0]                cfg_data_i,
  output logic                       cfg_ready_o,
  output logic                       ready_o,
  output logic                       err_o,
  output logic [NUM_HDRS-1:0]        parsed_valid_o,
  output logic [NUM_HDRS*ADDR_W-1:0] parsed_hdrs_o
);

  localparam int IW = (NUM_HDRS > 1) ? $clog2(NUM_HDRS) : 1;
  localparam logic [7:0]       NH_8 = 8'(NUM_HDRS);
  localparam logic [HID_W-1:0] NH_H = HID_W'(NUM_HDRS);
  localparam logic [HID_W-1:0] TS_H = HID_W'(TABLE_SIZE);

  typedef enum logic [1:0] {FREE, PARSE, DONE} state_t;
  state_t state_q, state_d;

  logic [15:0]       hdr_len_q   [NUM_HDRS];
  logic [7:0]        tag_start_q [NUM_HDRS];
  logic [7:0]        tag_len_q   [NUM_HDRS];
  logic              ent_vld_q   [NUM_HDRS][TABLE_SIZE];
  logic [7:0]        ent_next_q  [NUM_HDRS][TABLE_SIZE];
  logic [15:0]       ent_tag_q   [NUM_HDRS][TABLE_SIZE];

  logic [ADDR_W-1:0] base_q;
  logic [IW-1:0]     cur_q;
  logic [NUM_HDRS-1:0] visited_q;
  logic [ADDR_W-1:0] slot_q [NUM_HDRS];

  logic [7:0]        cur_tl;
  logic [15:0]       tag;
  logic              hit;
  logic [7:0]        hit_id;
  logic [IW-1:0]     nxt;
  logic              id_ok;
  logic              advance;
  logic              loop_err;
  logic [ADDR_W-1:0] nb;
  logic              cfg_wr;

  logic unused_bits;
  assign unused_bits = ^{cfg_data_i[30:24], mem_data_i[15:0]};

  assign cfg_ready_o = (state_q != PARSE);
  assign mem_we_o    = 1'b0;
  assign mem_data_o  = 32'h0;
  assign cfg_wr      = cfg_we_i && cfg_ready_o && (cfg_hdr_i < NH_H) &&
                       (!cfg_sel_i || (cfg_idx_i < TS_H));

  for (genvar g = 0; g < NUM_HDRS; g++) begin : g_slot
    assign parsed_hdrs_o[(NUM_HDRS-1-g)*ADDR_W +: ADDR_W] = slot_q[g];
  end

  always_comb begin
    cur_tl   = tag_len_q[cur_q];
    tag      = 16'h0;
    hit      = 1'b0;
    hit_id   = 8'h0;
    if (cur_tl == 8'd1)
      tag = {8'h00, mem_data_i[31:24]};
    else if (cur_tl >= 8'd2)
      tag = mem_data_i[31:16];
    // Lowest-index matching entry wins.
    for (int j = 0; j < TABLE_SIZE; j++) begin
      if (!hit && ent_vld_q[cur_q][j] && (ent_tag_q[cur_q][j] == tag)) begin
        hit    = 1'b1;
        hit_id = ent_next_q[cur_q][j];
      end
    end
    nxt      = hit_id[IW-1:0];
    id_ok    = (hit_id < NH_8);
    advance  = (cur_tl != 8'd0) && hit && id_ok && !visited_q[nxt];
    loop_err = (cur_tl != 8'd0) && hit && !(id_ok && !visited_q[nxt]);
    nb       = base_q + ADDR_W'(hdr_len_q[cur_q]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE:    if (start_i) state_d = PARSE;
      PARSE:   if (!advance) state_d = DONE;
      DONE:    if (!start_i) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FREE;
      mem_ce_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_width_o    <= 4'd0;
      ready_o        <= 1'b0;
      err_o          <= 1'b0;
      parsed_valid_o <= '0;
      base_q         <= '0;
      cur_q          <= '0;
      visited_q      <= '0;
      for (int i = 0; i < NUM_HDRS; i++) begin
        slot_q[i]      <= '1;
        hdr_len_q[i]   <= 16'd0;
        tag_start_q[i] <= 8'd0;
        tag_len_q[i]   <= 8'd0;
        for (int j = 0; j < TABLE_SIZE; j++) begin
          ent_vld_q[i][j]  <= 1'b0;
          ent_next_q[i][j] <= 8'd0;
          ent_tag_q[i][j]  <= 16'h0;
        end
      end
      // Default profile: Ethernet -> IPv4 on ethertype 0x0800.
      hdr_len_q[0]     <= 16'd14;
      tag_start_q[0]   <= 8'd12;
      tag_len_q[0]     <= 8'd2;
      ent_vld_q[0][0]  <= 1'b1;
      ent_next_q[0][0] <= 8'd1;
      ent_tag_q[0][0]  <= 16'h0800;
      hdr_len_q[1]     <= 16'd20;
      tag_start_q[1]   <= 8'd9;
      tag_len_q[1]     <= 8'd1;
    end else begin
      state_q <= state_d;
      if (cfg_wr) begin
        if (!cfg_sel_i) begin
          hdr_len_q[cfg_hdr_i[IW-1:0]]   <= cfg_data_i[31:16];
          tag_start_q[cfg_hdr_i[IW-1:0]] <= cfg_data_i[15:8];
          tag_len_q[cfg_hdr_i[IW-1:0]]   <= cfg_data_i[7:0];
        end else begin
          ent_vld_q[cfg_hdr_i[IW-1:0]][cfg_idx_i]  <= cfg_data_i[31];
          ent_next_q[cfg_hdr_i[IW-1:0]][cfg_idx_i] <= cfg_data_i[23:16];
          ent_tag_q[cfg_hdr_i[IW-1:0]][cfg_idx_i]  <= cfg_data_i[15:0];
        end
      end
      case (state_q)
        FREE: begin
          if (start_i) begin
            base_q         <= pkt_addr_i;
            cur_q          <= '0;
            visited_q      <= '0;
            parsed_valid_o <= '0;
            err_o          <= 1'b0;
            for (int i = 0; i < NUM_HDRS; i++) slot_q[i] <= '1;
            mem_addr_o     <= pkt_addr_i + ADDR_W'(tag_start_q[0]);
            mem_ce_o       <= (tag_len_q[0] != 8'd0);
            mem_width_o    <= 4'd4;
          end
        end
        PARSE: begin
          slot_q[cur_q]         <= base_q;
          parsed_valid_o[cur_q] <= 1'b1;
          visited_q[cur_q]      <= 1'b1;
          if (advance) begin
            cur_q      <= nxt;
            base_q     <= nb;
            mem_addr_o <= nb + ADDR_W'(tag_start_q[nxt]);
            mem_ce_o   <= (tag_len_q[nxt] != 8'd0);
          end else begin
            mem_ce_o <= 1'b0;
            ready_o  <= 1'b1;
            err_o    <= loop_err;
          end
        end
        DONE: begin
          if (!start_i) ready_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
